// File: rtl/sd_cmd_master.sv
// Command sequencer for sd_cmd_serial_host: builds SETTING/CMD, runs the
// REQ/ACK handshakes, checks the final response and recovers a hung host.
module sd_cmd_master #(
    parameter logic [2:0] WO_DELAY     = 3'd7,
    parameter int         HOST_RST_CYC = 4,
    parameter int         TMO_W        = 16
) (
    input  logic             SD_CLK_IN,
    input  logic             RST_IN,
    input  logic             start_i,
    input  logic [5:0]       cmd_index_i,
    input  logic [31:0]      cmd_arg_i,
    input  logic [1:0]       resp_type_i,
    input  logic             crc_check_i,
    input  logic             idx_check_i,
    input  logic [1:0]       blk_ctl_i,
    input  logic [1:0]       word_sel_i,
    input  logic [TMO_W-1:0] timeout_i,
    output logic [15:0]      setting_o,
    output logic [39:0]      cmd_o,
    output logic             req_o,
    input  logic             ack_i,
    input  logic             req_i,
    output logic             ack_o,
    input  logic [7:0]       status_i,
    input  logic [39:0]      resp_i,
    output logic             host_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       err_o,
    output logic [31:0]      resp_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_ACCEPT,
        S_WAIT,
        S_SACK,
        S_DRAIN,
        S_FINISH,
        S_RECOV
    } state_t;

    localparam logic [7:0] RST_LAST = 8'(HOST_RST_CYC - 1);

    state_t state;
    state_t next;

    logic [5:0]       idx_q;
    logic [1:0]       rtype_q;
    logic             crc_q;
    logic             ichk_q;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] cnt;
    logic [7:0]       rcnt;
    logic             fin_q;

    logic             accept;
    logic             counting;
    logic             tmo_hit;
    logic             st_take;
    logic [1:0]       rtype_n;
    logic [6:0]       len_n;
    logic [2:0]       dly_n;
    logic             unused_bits;

    assign unused_bits = ^{status_i[7], status_i[4:0], resp_i[39:38]};

    assign accept   = (state == S_IDLE) && start_i;
    assign counting = (state == S_ACCEPT) || (state == S_WAIT) ||
                      (state == S_SACK) || (state == S_DRAIN);
    assign tmo_hit  = counting && (tmo_q != '0) && (cnt == tmo_q);
    assign st_take  = (state == S_WAIT) && req_i && !tmo_hit;

    // Reserved response type 11 behaves as a 48-bit response.
    assign rtype_n = (resp_type_i == 2'b11) ? 2'b01 : resp_type_i;
    assign len_n   = (rtype_n == 2'b01) ? 7'd39 :
                     (rtype_n == 2'b10) ? 7'd127 : 7'd0;
    assign dly_n   = (rtype_n == 2'b00) ? WO_DELAY : 3'd0;

    assign req_o      = (state == S_ACCEPT);
    assign ack_o      = (state == S_SACK);
    assign done_o     = (state == S_FINISH);
    assign busy_o     = (state != S_IDLE);
    assign host_rst_o = (state == S_RECOV);

    always_ff @(posedge SD_CLK_IN or negedge RST_IN) begin
        if (!RST_IN) state <= S_IDLE;
        else         state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:   if (start_i) next = S_SEND;
            S_SEND:   if (ack_i) next = S_ACCEPT;
            S_ACCEPT: begin
                if (tmo_hit)     next = S_RECOV;
                else if (!ack_i) next = S_WAIT;
            end
            S_WAIT: begin
                if (tmo_hit)    next = S_RECOV;
                else if (req_i) next = S_SACK;
            end
            S_SACK: begin
                if (tmo_hit)     next = S_RECOV;
                else if (!req_i) next = fin_q ? S_DRAIN : S_WAIT;
            end
            S_DRAIN: begin
                if (tmo_hit)    next = S_RECOV;
                else if (ack_i) next = S_FINISH;
            end
            S_FINISH: next = S_IDLE;
            S_RECOV:  if (rcnt == RST_LAST) next = S_FINISH;
            default:  next = S_IDLE;
        endcase
    end

    always_ff @(posedge SD_CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            setting_o <= '0;
            cmd_o     <= '0;
            idx_q     <= '0;
            rtype_q   <= '0;
            crc_q     <= 1'b0;
            ichk_q    <= 1'b0;
            tmo_q     <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            fin_q     <= 1'b0;
            err_o     <= '0;
            resp_o    <= '0;
        end else begin
            if (accept) begin
                setting_o <= {1'b0, word_sel_i, blk_ctl_i, dly_n,
                              crc_check_i, len_n};
                cmd_o     <= {2'b01, cmd_index_i, cmd_arg_i};
                idx_q     <= cmd_index_i;
                rtype_q   <= rtype_n;
                crc_q     <= crc_check_i;
                ichk_q    <= idx_check_i;
                tmo_q     <= timeout_i;
                cnt       <= '0;
                err_o     <= '0;
            end else if (counting && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end

            rcnt <= (state == S_RECOV) ? rcnt + 8'd1 : 8'd0;

            if (tmo_hit) begin
                err_o[3] <= (state == S_ACCEPT);
                err_o[0] <= (state != S_ACCEPT);
            end

            if (st_take) begin
                fin_q <= status_i[6];
                if (status_i[6]) begin
                    resp_o <= resp_i[31:0];
                    if (rtype_q != 2'b00) begin
                        err_o[1] <= crc_q & ~status_i[5];
                        err_o[2] <= ichk_q & (resp_i[37:32] != idx_q) &
                                    (rtype_q == 2'b01);
                    end
                end
            end
        end
    end

endmodule
